// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/request bundle between the intersection controller and its environment.
// The controller side uses the slave modport; the request source / lamp sink uses master.
interface traffic_phase_ctrl_if #(
    parameter int NUM_PHASES = 2,
    parameter int PH_W       = $clog2(NUM_PHASES)
);
    logic [NUM_PHASES-1:0] ped_req;
    logic                  flash_req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] walk;
    logic [PH_W-1:0]       phase;
    logic                  flashing;

    modport master (
        output ped_req, flash_req,
        input  red, yellow, green, walk, phase, flashing
    );

    modport slave (
        input  ped_req, flash_req,
        output red, yellow, green, walk, phase, flashing
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-phase round-robin intersection controller with pedestrian WALK and maintenance flash.
// All lamp outputs are registered from next-state values, so they move with the state register.
module traffic_phase_ctrl #(
    parameter int CLK_FREQ      = 27_000_000,
    parameter int NUM_PHASES    = 2,
    parameter int GREEN_MS      = 10000,
    parameter int YELLOW_MS     = 3000,
    parameter int ALL_RED_MS    = 1000,
    parameter int WALK_MS       = 4000,
    parameter int FLASH_HALF_MS = 500
) (
    input  logic sys_clk,
    input  logic rst_n,
    traffic_phase_ctrl_if.slave bus
);
    localparam int CPM   = CLK_FREQ / 1000;
    localparam int PH_W  = $clog2(NUM_PHASES);
    localparam int PS_W  = (CPM > 1) ? $clog2(CPM) : 1;
    localparam int MAX_A = (GREEN_MS > YELLOW_MS) ? GREEN_MS : YELLOW_MS;
    localparam int MAX_B = (ALL_RED_MS > FLASH_HALF_MS) ? ALL_RED_MS : FLASH_HALF_MS;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_MS = (MAX_C > WALK_MS) ? MAX_C : WALK_MS;
    localparam int TM_W  = $clog2(MAX_MS + 1);

    // S_INIT holds the register in reset so OFF is visible for one full cycle after release.
    typedef enum logic [2:0] {
        S_INIT, S_OFF, S_ALL_RED, S_GREEN, S_YELLOW, S_FLASH
    } state_t;

    state_t                state_q, state_d;
    logic [PS_W-1:0]       presc_q;
    logic [TM_W-1:0]       timer_q;
    logic [TM_W-1:0]       dur_m1;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [PH_W-1:0]       nxt_q, nxt_d;
    logic [NUM_PHASES-1:0] pend_q, pend_d;
    logic                  walk_on_q, walk_on_d;
    logic                  flash_on_q, flash_on_d;
    logic                  restart;
    logic                  tick;
    logic                  tm_end;

    logic [NUM_PHASES-1:0] red_q, red_d;
    logic [NUM_PHASES-1:0] yellow_q, yellow_d;
    logic [NUM_PHASES-1:0] green_q, green_d;
    logic [NUM_PHASES-1:0] walk_q, walk_d;
    logic                  flashing_q, flashing_d;
    logic [NUM_PHASES-1:0] onehot;

    assign tick = (presc_q == PS_W'(CPM - 1));

    always_comb begin
        dur_m1 = '0;
        case (state_q)
            S_ALL_RED: dur_m1 = TM_W'(ALL_RED_MS - 1);
            S_GREEN:   dur_m1 = TM_W'(GREEN_MS - 1);
            S_YELLOW:  dur_m1 = TM_W'(YELLOW_MS - 1);
            S_FLASH:   dur_m1 = TM_W'(FLASH_HALF_MS - 1);
            default:   dur_m1 = '0;
        endcase
    end

    assign tm_end = tick && (timer_q == dur_m1);

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        nxt_d      = nxt_q;
        walk_on_d  = walk_on_q;
        flash_on_d = flash_on_q;
        pend_d     = pend_q | bus.ped_req;
        restart    = 1'b0;
        case (state_q)
            S_INIT: state_d = S_OFF;
            S_OFF:  state_d = S_ALL_RED;
            S_ALL_RED: begin
                if (tm_end) begin
                    if (bus.flash_req) begin
                        state_d    = S_FLASH;
                        flash_on_d = 1'b1;
                        nxt_d      = '0;
                    end else begin
                        state_d   = S_GREEN;
                        ph_d      = nxt_q;
                        nxt_d     = (nxt_q == PH_W'(NUM_PHASES - 1)) ? '0 : nxt_q + PH_W'(1);
                        walk_on_d = pend_q[nxt_q];
                        // Serving clears the latch; a press on this very edge stays pending.
                        pend_d[nxt_q] = bus.ped_req[nxt_q];
                    end
                end
            end
            S_GREEN: begin
                if (tm_end) begin
                    state_d   = S_YELLOW;
                    walk_on_d = 1'b0;
                end else if (tick && timer_q == TM_W'(WALK_MS - 1)) begin
                    walk_on_d = 1'b0;
                end
            end
            S_YELLOW: if (tm_end) state_d = S_ALL_RED;
            S_FLASH: begin
                if (tm_end) begin
                    if (!bus.flash_req) begin
                        state_d    = S_ALL_RED;
                        flash_on_d = 1'b0;
                    end else begin
                        flash_on_d = ~flash_on_q;
                        restart    = 1'b1;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
        if (state_d != state_q) restart = 1'b1;
    end

    always_comb begin
        onehot       = '0;
        onehot[ph_d] = 1'b1;
        red_d        = '0;
        yellow_d     = '0;
        green_d      = '0;
        walk_d       = '0;
        flashing_d   = 1'b0;
        case (state_d)
            S_ALL_RED: red_d = '1;
            S_GREEN: begin
                green_d = onehot;
                red_d   = ~onehot;
                if (walk_on_d) walk_d = onehot;
            end
            S_YELLOW: begin
                yellow_d = onehot;
                red_d    = ~onehot;
            end
            S_FLASH: begin
                yellow_d   = {NUM_PHASES{flash_on_d}};
                flashing_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            presc_q    <= '0;
            timer_q    <= '0;
            ph_q       <= '0;
            nxt_q      <= '0;
            pend_q     <= '0;
            walk_on_q  <= 1'b0;
            flash_on_q <= 1'b0;
            red_q      <= '0;
            yellow_q   <= '0;
            green_q    <= '0;
            walk_q     <= '0;
            flashing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            nxt_q      <= nxt_d;
            pend_q     <= pend_d;
            walk_on_q  <= walk_on_d;
            flash_on_q <= flash_on_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            green_q    <= green_d;
            walk_q     <= walk_d;
            flashing_q <= flashing_d;
            if (restart || tick) presc_q <= '0;
            else                 presc_q <= presc_q + PS_W'(1);
            if (restart)   timer_q <= '0;
            else if (tick) timer_q <= timer_q + TM_W'(1);
        end
    end

    assign bus.red      = red_q;
    assign bus.yellow   = yellow_q;
    assign bus.green    = green_q;
    assign bus.walk     = walk_q;
    assign bus.phase    = ph_q;
    assign bus.flashing = flashing_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus a randomised run, all checked
// against a countdown-schedule model of the intersection.
module tb_traffic_phase_ctrl;
    localparam int CLK_FREQ = 1000;
    localparam int CPM      = CLK_FREQ / 1000;
    localparam int N        = 2;
    localparam int PH_W     = $clog2(N);
    localparam int G_MS     = 10;
    localparam int Y_MS     = 3;
    localparam int AR_MS    = 2;
    localparam int W_MS     = 4;
    localparam int FH_MS    = 5;
    localparam int OW       = 4 * N + PH_W + 1;

    localparam int SEG_INIT = 0, SEG_OFF = 1, SEG_AR = 2, SEG_GRN = 3, SEG_YEL = 4, SEG_FL = 5;

    logic sys_clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    traffic_phase_ctrl_if #(.NUM_PHASES(N)) bus ();

    traffic_phase_ctrl #(
        .CLK_FREQ(CLK_FREQ), .NUM_PHASES(N), .GREEN_MS(G_MS), .YELLOW_MS(Y_MS),
        .ALL_RED_MS(AR_MS), .WALK_MS(W_MS), .FLASH_HALF_MS(FH_MS)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    wire [OW-1:0] dut_out = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase, bus.flashing};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: current segment, cycles left in it, phase served, next phase, WALK cycles left.
    int         m_seg, m_left, m_phase, m_next, m_walk;
    logic       m_fon;
    logic [N-1:0] m_pend;

    task automatic model_reset();
        m_seg = SEG_INIT; m_left = 0; m_phase = 0; m_next = 0; m_walk = 0;
        m_fon = 1'b0; m_pend = '0;
    endtask

    task automatic model_step(input logic [N-1:0] ped, input logic fl);
        logic [N-1:0] pold;
        pold = m_pend;
        case (m_seg)
            SEG_INIT: m_seg = SEG_OFF;
            SEG_OFF: begin m_seg = SEG_AR; m_left = AR_MS * CPM; end
            default: begin
                m_left--;
                if (m_walk > 0) m_walk--;
                if (m_left == 0) begin
                    case (m_seg)
                        SEG_AR: begin
                            if (fl) begin
                                m_seg = SEG_FL; m_left = FH_MS * CPM; m_fon = 1'b1; m_next = 0;
                            end else begin
                                m_seg = SEG_GRN; m_left = G_MS * CPM;
                                m_phase = m_next; m_next = (m_next + 1) % N;
                                m_walk = pold[m_phase] ? W_MS * CPM : 0;
                                m_pend[m_phase] = 1'b0;
                            end
                        end
                        SEG_GRN: begin m_seg = SEG_YEL; m_left = Y_MS * CPM; m_walk = 0; end
                        SEG_YEL: begin m_seg = SEG_AR; m_left = AR_MS * CPM; end
                        default: begin
                            if (!fl) begin m_seg = SEG_AR; m_left = AR_MS * CPM; m_fon = 1'b0; end
                            else begin m_fon = ~m_fon; m_left = FH_MS * CPM; end
                        end
                    endcase
                end
            end
        endcase
        m_pend = m_pend | ped;
    endtask

    function automatic logic [OW-1:0] exp_out();
        logic [N-1:0] r, y, g, w, oh;
        r = '0; y = '0; g = '0; w = '0; oh = '0;
        oh[m_phase] = 1'b1;
        case (m_seg)
            SEG_AR:  r = '1;
            SEG_GRN: begin g = oh; r = ~oh; if (m_walk > 0) w = oh; end
            SEG_YEL: begin y = oh; r = ~oh; end
            SEG_FL:  y = m_fon ? '1 : '0;
            default: ;
        endcase
        return {r, y, g, w, PH_W'(m_phase), (m_seg == SEG_FL)};
    endfunction

    // One rising edge; the model sees the same inputs the DUT samples, outputs read 1 ns later.
    task automatic cyc();
        @(posedge sys_clk);
        model_step(bus.ped_req, bus.flash_req);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.ped_req = '0; bus.flash_req = 1'b0;
        repeat (2) @(posedge sys_clk);
        model_reset();
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        bus.ped_req = '0; bus.flash_req = 1'b0;
        #1;
        n_cmp++;
        if (dut_out !== '0) begin
            n_err++; $display("FAIL reset_values got %h want 0", dut_out);
        end
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            cyc();
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL reset_seq edge %0d got %h want %h", e, dut_out, exp_out());
            end
            if (e == 1 || e == 2 || e == 4 || e == 19 || e == 34) begin
                logic [3*N-1:0] want;
                case (e)
                    1:       want = {2'b00, 2'b00, 2'b00};
                    2:       want = {2'b11, 2'b00, 2'b00};
                    19:      want = {2'b01, 2'b00, 2'b10};
                    default: want = {2'b10, 2'b00, 2'b01};
                endcase
                n_cmp++;
                if ({bus.red, bus.yellow, bus.green} !== want) begin
                    n_err++; $display("FAIL reset_sched edge %0d got %h want %h", e,
                                      {bus.red, bus.yellow, bus.green}, want);
                end
            end
        end
    endtask

    task automatic test_ped_single();
        int wcnt;
        do_reset();
        wcnt = 0;
        for (int e = 1; e <= 80; e++) begin
            bus.ped_req = (e == 7) ? 2'b10 : 2'b00;
            cyc();
            wcnt += $countones(bus.walk);
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL ped_single edge %0d got %h want %h", e, dut_out, exp_out());
            end
            if (e == 19 || e == 23) begin
                n_cmp++;
                if (bus.walk !== ((e == 19) ? 2'b10 : 2'b00)) begin
                    n_err++; $display("FAIL ped_single_walk edge %0d got %b", e, bus.walk);
                end
            end
        end
        n_cmp++;
        if (wcnt != 4) begin
            n_err++; $display("FAIL ped_single_count got %0d want 4", wcnt);
        end
    endtask

    task automatic test_ped_hold();
        int wcnt;
        do_reset();
        wcnt = 0;
        for (int e = 1; e <= 60; e++) begin
            bus.ped_req = (e <= 8) ? 2'b01 : 2'b00;
            cyc();
            wcnt += $countones(bus.walk);
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL ped_hold edge %0d got %h want %h", e, dut_out, exp_out());
            end
            if (e == 34) begin
                n_cmp++;
                if (bus.walk !== 2'b01) begin
                    n_err++; $display("FAIL ped_hold_relatch got %b want 01", bus.walk);
                end
            end
        end
        n_cmp++;
        if (wcnt != 8) begin
            n_err++; $display("FAIL ped_hold_count got %0d want 8", wcnt);
        end
    endtask

    task automatic test_flash();
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            bus.flash_req = (e >= 7 && e <= 30);
            cyc();
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL flash edge %0d got %h want %h", e, dut_out, exp_out());
            end
            if (e == 13 || e == 19 || e == 24 || e == 34 || e == 36) begin
                logic [3*N:0] want;
                case (e)
                    13:      want = {1'b0, 2'b10, 2'b00, 2'b01};
                    19:      want = {1'b1, 2'b00, 2'b11, 2'b00};
                    24:      want = {1'b1, 2'b00, 2'b00, 2'b00};
                    34:      want = {1'b0, 2'b11, 2'b00, 2'b00};
                    default: want = {1'b0, 2'b10, 2'b00, 2'b01};
                endcase
                n_cmp++;
                if ({bus.flashing, bus.red, bus.yellow, bus.green} !== want) begin
                    n_err++; $display("FAIL flash_sched edge %0d got %h want %h", e,
                                      {bus.flashing, bus.red, bus.yellow, bus.green}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int wcnt;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            bus.ped_req = (e == 20) ? 2'b01 : 2'b00;
            cyc();
        end
        n_cmp++;
        if (bus.yellow !== 2'b10) begin
            n_err++; $display("FAIL reset_mid_pre got yellow %b want 10", bus.yellow);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out !== '0) begin
            n_err++; $display("FAIL reset_mid_async got %h want 0", dut_out);
        end
        model_reset();
        @(negedge sys_clk);
        rst_n = 1'b1;
        wcnt = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc();
            wcnt += $countones(bus.walk);
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL reset_mid edge %0d got %h want %h", e, dut_out, exp_out());
            end
        end
        n_cmp++;
        if (wcnt != 0) begin
            n_err++; $display("FAIL reset_mid_pend got walk cycles %0d want 0", wcnt);
        end
    endtask

    task automatic test_random();
        logic fl;
        do_reset();
        fl = 1'b0;
        for (int e = 1; e <= 3000; e++) begin
            if ($urandom_range(0, 149) == 0) fl = ~fl;
            bus.flash_req = fl;
            bus.ped_req   = N'($urandom_range(0, 3)) & N'(($urandom_range(0, 5) == 0) ? 3 : 0);
            cyc();
            n_cmp++;
            if (dut_out !== exp_out()) begin
                n_err++; $display("FAIL random edge %0d got %h want %h", e, dut_out, exp_out());
            end
            if (!bus.flashing) begin
                n_cmp++;
                if ($countones(bus.yellow | bus.green) > 1) begin
                    n_err++; $display("FAIL safety_nonred edge %0d got y %b g %b", e, bus.yellow, bus.green);
                end
            end
            n_cmp++;
            if ((bus.walk & ~bus.green) != '0 || $countones(bus.walk) > 1) begin
                n_err++; $display("FAIL safety_walk edge %0d got walk %b green %b", e, bus.walk, bus.green);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1;
        bus.ped_req = '0; bus.flash_req = 1'b0;
        model_reset();
        test_reset();
        test_ped_single();
        test_ped_hold();
        test_flash();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
